// File: rtl/half_adder.sv
// Registered, lane-parallel half adder with a valid/ready stream interface.
// Each lane produces sum = a ^ b and carry = a & b. Lanes never interact.
// A result appears one cycle after the input transfer that produced it.
// Storage is the output register plus one skid entry, which gives two results in total.
// The skid entry lets in_ready be a plain flop output, so it has no combinational
// path from out_ready.
module half_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic             carry_any
);

  logic             skid_valid;
  logic [WIDTH-1:0] skid_sum;
  logic [WIDTH-1:0] skid_carry;

  logic [WIDTH-1:0] new_sum;
  logic [WIDTH-1:0] new_carry;
  logic             accept;
  logic             out_free;

  // Per-lane arithmetic on the incoming operands, with transfer qualifiers.
  always_comb begin
    new_sum   = a ^ b;
    new_carry = a & b;
    accept    = in_valid & in_ready;
    // The output register can take a new value if it is empty or is being drained this edge.
    out_free  = ~out_valid | out_ready;
  end

  // The skid entry is the only thing that can block the input, so in_ready mirrors its emptiness.
  always_comb begin
    in_ready = ~skid_valid;
  end

  // Output register and skid entry update. A waiting skid result always goes out first, to keep FIFO order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      sum        <= '0;
      carry      <= '0;
      carry_any  <= 1'b0;
      skid_valid <= 1'b0;
      skid_sum   <= '0;
      skid_carry <= '0;
    end else if (out_free) begin
      if (skid_valid) begin
        // When the skid is full, in_ready is low, so no new pair can arrive on this edge.
        out_valid  <= 1'b1;
        sum        <= skid_sum;
        carry      <= skid_carry;
        carry_any  <= |skid_carry;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        sum       <= new_sum;
        carry     <= new_carry;
        carry_any <= |new_carry;
      end else begin
        // Data is left as it was, so it stays defined while the stage is empty.
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      // Output is stalled but holds a result; park the new one behind it.
      skid_valid <= 1'b1;
      skid_sum   <= new_sum;
      skid_carry <= new_carry;
    end
  end

endmodule

// File: tb/tb_half_adder.sv
// Self-checking bench for half_adder (WIDTH=4).
// It runs directed and random stimulus against a queue-based reference model.
module tb_half_adder;
  localparam int W = 4;

  typedef struct {
    logic [W-1:0] s;
    logic [W-1:0] c;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic [W-1:0] carry;
  logic         carry_any;

  int   compared   = 0;
  int   mismatched = 0;
  res_t q[$];
  int   run_len;

  half_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry(carry), .carry_any(carry_any)
  );

  always #5 clk = ~clk;

  // Reference result: add the two lane bits as integers, then split the total into sum and carry.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    res_t r;
    for (int i = 0; i < W; i++) begin
      int t;
      t = int'(x[i]) + int'(y[i]);
      r.s[i] = (t % 2) != 0;
      r.c[i] = (t / 2) != 0;
    end
    return r;
  endfunction

  task automatic cmp(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic check(input string tag);
    cmp({tag, ".in_ready"}, W'(in_ready), W'(q.size() < 2));
    cmp({tag, ".out_valid"}, W'(out_valid), W'(q.size() > 0));
    if (q.size() > 0) begin
      cmp({tag, ".sum"}, sum, q[0].s);
      cmp({tag, ".carry"}, carry, q[0].c);
      cmp({tag, ".carry_any"}, W'(carry_any), W'(q[0].c != 0));
    end
  endtask

  // One clock cycle: check the outputs, drive the inputs, and advance the model by the transfers this cycle makes.
  task automatic step(input logic iv, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic ordy, input string tag);
    bit acc, drn;
    check(tag);
    in_valid  = iv;
    a         = x;
    b         = y;
    out_ready = ordy;
    acc = iv && (q.size() < 2);
    drn = (q.size() > 0) && ordy;
    @(posedge clk);
    if (drn) void'(q.pop_front());
    if (acc) q.push_back(model(x, y));
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles, input string tag);
    rst_n     = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a         = W'($urandom);
    b         = W'($urandom);
    repeat (cycles) @(posedge clk);
    q.delete();
    @(negedge clk);
    cmp({tag, ".out_valid"}, W'(out_valid), '0);
    cmp({tag, ".sum"}, sum, '0);
    cmp({tag, ".carry"}, carry, '0);
    cmp({tag, ".carry_any"}, W'(carry_any), '0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
  endtask

  initial begin
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    @(negedge clk);

    do_reset(2, "reset");
    step(1'b0, '0, '0, 1'b1, "post_reset");

    // Truth table on lane 0; all other lanes are held at zero.
    step(1'b1, 4'b0000, 4'b0000, 1'b1, "tt00");
    step(1'b1, 4'b0000, 4'b0001, 1'b1, "tt01");
    step(1'b1, 4'b0001, 4'b0000, 1'b1, "tt10");
    step(1'b1, 4'b0001, 4'b0001, 1'b1, "tt11");
    step(1'b0, '0, '0, 1'b1, "tt_tail");

    step(1'b1, 4'b1100, 4'b1010, 1'b1, "lanes_in");
    cmp("lanes.sum", sum, 4'b0110);
    cmp("lanes.carry", carry, 4'b1000);
    cmp("lanes.carry_any", W'(carry_any), W'(1));
    step(1'b0, '0, '0, 1'b1, "lanes_tail");

    step(1'b1, 4'b0011, 4'b0101, 1'b0, "bp_push1");
    step(1'b1, 4'b1111, 4'b1111, 1'b0, "bp_push2");
    cmp("bp.full_in_ready", W'(in_ready), W'(0));
    step(1'b1, 4'b1001, 4'b0110, 1'b0, "bp_push3");
    step(1'b0, '0, '0, 1'b0, "bp_stall");
    step(1'b0, '0, '0, 1'b1, "bp_drain1");
    step(1'b0, '0, '0, 1'b1, "bp_drain2");
    step(1'b0, '0, '0, 1'b1, "bp_empty");

    run_len = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, W'($urandom), W'($urandom), 1'b1, "thru");
      if (out_valid === 1'b1) run_len++;
    end
    cmp("thru.run_len", W'(run_len), W'(8));
    step(1'b0, '0, '0, 1'b1, "thru_tail");

    step(1'b1, 4'b0110, 4'b0111, 1'b0, "mr_push1");
    step(1'b1, 4'b1110, 4'b1011, 1'b0, "mr_push2");
    do_reset(1, "mid_reset");
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1, "mr_after");

    for (int i = 0; i < 300; i++)
      step(1'($urandom), W'($urandom), W'($urandom), 1'($urandom_range(0, 3) != 0), "rand");
    check("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
